decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32: register/datapath width (>=16).
REQ-002 Parameter NREGS, default 32: register count, power of two; ADDR_W = log2(NREGS), fixed at 5 for MIPS encoding.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 if_valid  in  1  IF presents a valid instruction.
REQ-006 if_instr  in  32  fetched instruction.
REQ-007 if_pcplus4  in  DATA_W  PC+4 of fetched instruction.
REQ-008 flush  in  1  kill the instruction entering/held in ID.
REQ-009 ex_memtoreg  in  1  instruction in EX is a load.
REQ-010 ex_rt  in  ADDR_W  load destination in EX.
REQ-011 wb_we / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  register write-back.
REQ-012 stall  out  1  hold IF and ID; insert bubble into EX.
REQ-013 id_valid  out  1  ID holds a valid instruction.
REQ-014 id_pcplus4  out  DATA_W  registered PC+4.
REQ-015 rs_data, rt_data  out  DATA_W  register reads.
REQ-016 rs_addr, rt_addr, rd_addr, shamt  out  5 each  instruction fields (rd_addr=31 for jal).
REQ-017 imm_sext, imm_zext  out  DATA_W  sign/zero-extended imm[15:0].
REQ-018 reg_write, mem_to_reg, mem_write, branch, jump, reg_dst  out  1 each  control.
REQ-019 alu_op, alu_funct  out  6 each  op and funct fields.
REQ-020 illegal  out  1  valid instruction not in the decode table.

Function
REQ-021 IF/ID register priority per rising edge: flush -> valid=0, instr=0; else stall -> hold; else load if_valid, if_instr, if_pcplus4.
REQ-022 stall = id_valid & ex_memtoreg & (ex_rt!=0) & (ex_rt==rs_addr | ex_rt==rt_addr), combinational.
REQ-023 When stall=1 or id_valid=0, all controls of REQ-018 and illegal SHALL be 0; field/data outputs stay decoded.
REQ-024 Decode: lw rw+m2r; sw mw; R-type add/addu/sub/subu/and/or/xor/nor/slt/sll/srl/sra/sllv/srlv/srav rw+rdst; addi/addiu/andi/ori/xori rw; beq/bne br; j jump; jr jump; jal rw+jump+rdst with rd_addr=31.
REQ-025 Unlisted op/funct with id_valid=1, stall=0: illegal=1, all other controls 0.
REQ-026 Register file: NREGS x DATA_W; write on rising edge when wb_we=1 and wb_addr!=0; register 0 always reads 0.
REQ-027 Reads combinational; read latency 0 after IF/ID load; id_valid follows if_valid by one cycle.
REQ-028 Simultaneous flush and stall: flush wins; stall deasserts next cycle because id_valid=0.
REQ-029 wb_addr >= NREGS (NREGS<32): write ignored; reads of such addresses return 0.

Reset
REQ-030 RST_N=0 asynchronously clears IF/ID register (valid=0, instr=0, pcplus4=0) and all registers to 0.
REQ-031 During and after reset until first load, all outputs are 0 except imm/field outputs derived from instr=0 (all 0).
REQ-032 Reset mid-stall drops the held instruction; first post-reset edge loads IF normally.

Configuration
REQ-033 Macro DECODE_BYPASS_EN defined: a read whose address equals wb_addr with wb_we=1, wb_addr!=0 returns wb_data in the same cycle (write-through).
REQ-034 Macro undefined: reads return the stored value; new data visible the cycle after the write edge.

Verification
REQ-035 Reset: RST_N=0 mid-cycle -> all outputs 0 immediately; read r5 -> 0.
REQ-036 Write/read: wb_we=1, wb_addr=5, wb_data=0x1234; next cycle instr add $3,$5,$0 -> rs_data=0x1234, reg_write=1, reg_dst=1, rd_addr=3.
REQ-037 Bypass: same-cycle write r7=0xCAFE and ID reading r7 -> rs_data=0xCAFE with DECODE_BYPASS_EN, old value without.
REQ-038 Load-use: ex_memtoreg=1, ex_rt=4, ID instr rs=4 -> stall=1, controls 0, ID holds two edges until ex_memtoreg=0; ex_rt=0 -> stall=0.
REQ-039 Flush+stall same edge -> id_valid=0 next cycle, stall=0; r0 write 0xFFFF ignored, r0 reads 0.
REQ-040 Decode: jal -> rd_addr=31, jump=1, reg_write=1; op=0x3F -> illegal=1; addi imm=0x8000 -> imm_sext=0xFFFF8000, imm_zext=0x00008000.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, EX hazard info and write-back in; decoded fields and controls out.
// The slave modport is the decode stage; the master modport is whoever drives IF/EX/WB.
interface decode_stage_if #(
  parameter int DATA_W = 32
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [DATA_W-1:0] if_pcplus4;
  logic              flush;
  logic              ex_memtoreg;
  logic [4:0]        ex_rt;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              stall;
  logic              id_valid;
  logic [DATA_W-1:0] id_pcplus4;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [4:0]        rd_addr;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic              reg_write;
  logic              mem_to_reg;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic              reg_dst;
  logic [5:0]        alu_op;
  logic [5:0]        alu_funct;
  logic              illegal;

  modport slave (
    input  if_valid, if_instr, if_pcplus4, flush, ex_memtoreg, ex_rt,
           wb_we, wb_addr, wb_data,
    output stall, id_valid, id_pcplus4, rs_data, rt_data, rs_addr, rt_addr,
           rd_addr, shamt, imm_sext, imm_zext, reg_write, mem_to_reg,
           mem_write, branch, jump, reg_dst, alu_op, alu_funct, illegal
  );

  modport master (
    output if_valid, if_instr, if_pcplus4, flush, ex_memtoreg, ex_rt,
           wb_we, wb_addr, wb_data,
    input  stall, id_valid, id_pcplus4, rs_data, rt_data, rs_addr, rt_addr,
           rd_addr, shamt, imm_sext, imm_zext, reg_write, mem_to_reg,
           mem_write, branch, jump, reg_dst, alu_op, alu_funct, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, register file, decoder, load-use stall; outputs 0 cycles after IF/ID load, stall holds IF/ID.
// DECODE_BYPASS_EN: when defined, register reads see a same-cycle write-back (write-through).
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input logic           CLK,
  input logic           RST_N,
  decode_stage_if.slave bus
);
  localparam int        IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_pcplus4;
  logic [DATA_W-1:0] r_rf [NREGS];

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic              w_stall;
  logic              w_ctl_en;
  logic              w_legal;
  logic              w_rw;
  logic              w_m2r;
  logic              w_mw;
  logic              w_br;
  logic              w_jmp;
  logic              w_rdst;
  logic              w_wb_ok;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  function automatic logic in_range(input logic [4:0] a);
    return ({1'b0, a} < NREGS_L);
  endfunction

  assign w_op    = r_instr[31:26];
  assign w_funct = r_instr[5:0];
  assign w_rs    = r_instr[25:21];
  assign w_rt    = r_instr[20:16];

  // Load-use hazard: the load result is not available until after EX/MEM.
  assign w_stall  = r_valid & bus.ex_memtoreg & (bus.ex_rt != 5'd0) &
                    ((bus.ex_rt == w_rs) | (bus.ex_rt == w_rt));
  assign w_ctl_en = r_valid & ~w_stall;

  // Flush beats stall so a killed instruction can never keep itself alive.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pcplus4 <= '0;
    end else if (bus.flush) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
    end else if (!w_stall) begin
      r_valid   <= bus.if_valid;
      r_instr   <= bus.if_instr;
      r_pcplus4 <= bus.if_pcplus4;
    end
  end

  assign w_wb_ok = bus.wb_we & (bus.wb_addr != 5'd0) & in_range(bus.wb_addr);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_ok) begin
      r_rf[bus.wb_addr[IDX_W-1:0]] <= bus.wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if ((a != 5'd0) && in_range(a)) v = r_rf[a[IDX_W-1:0]];
`ifdef DECODE_BYPASS_EN
    if (w_wb_ok && (bus.wb_addr == a)) v = bus.wb_data;
`endif
    return v;
  endfunction

  assign w_rs_data = rf_read(w_rs);
  assign w_rt_data = rf_read(w_rt);

  always_comb begin
    w_legal = 1'b0;
    w_rw    = 1'b0;
    w_m2r   = 1'b0;
    w_mw    = 1'b0;
    w_br    = 1'b0;
    w_jmp   = 1'b0;
    w_rdst  = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
            w_legal = 1'b1;
            w_rw    = 1'b1;
            w_rdst  = 1'b1;
          end
          FN_JR: begin
            w_legal = 1'b1;
            w_jmp   = 1'b1;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_LW: begin
        w_legal = 1'b1;
        w_rw    = 1'b1;
        w_m2r   = 1'b1;
      end
      OP_SW: begin
        w_legal = 1'b1;
        w_mw    = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        w_legal = 1'b1;
        w_rw    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_legal = 1'b1;
        w_br    = 1'b1;
      end
      OP_J: begin
        w_legal = 1'b1;
        w_jmp   = 1'b1;
      end
      OP_JAL: begin
        w_legal = 1'b1;
        w_rw    = 1'b1;
        w_jmp   = 1'b1;
        w_rdst  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign bus.stall      = w_stall;
  assign bus.id_valid   = r_valid;
  assign bus.id_pcplus4 = r_pcplus4;
  assign bus.rs_data    = w_rs_data;
  assign bus.rt_data    = w_rt_data;
  assign bus.rs_addr    = w_rs;
  assign bus.rt_addr    = w_rt;
  assign bus.rd_addr    = (w_op == OP_JAL) ? 5'd31 : r_instr[15:11];
  assign bus.shamt      = r_instr[10:6];
  assign bus.imm_sext   = DATA_W'($signed(r_instr[15:0]));
  assign bus.imm_zext   = DATA_W'(r_instr[15:0]);
  assign bus.alu_op     = w_op;
  assign bus.alu_funct  = w_funct;

  // Controls are squashed for bubbles and stalls; fields above stay decoded.
  assign bus.reg_write  = w_ctl_en & w_rw;
  assign bus.mem_to_reg = w_ctl_en & w_m2r;
  assign bus.mem_write  = w_ctl_en & w_mw;
  assign bus.branch     = w_ctl_en & w_br;
  assign bus.jump       = w_ctl_en & w_jmp;
  assign bus.reg_dst    = w_ctl_en & w_rdst;
  assign bus.illegal    = w_ctl_en & ~w_legal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, register file, bypass, load-use stall, flush, decode table.
module tb_decode_stage;
  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  decode_stage_if #(.DATA_W(32)) bus ();

  decode_stage #(.DATA_W(32), .NREGS(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {reg_write, mem_to_reg, mem_write, branch, jump, reg_dst, illegal}
  logic [6:0] w_ctl;
  assign w_ctl = {bus.reg_write, bus.mem_to_reg, bus.mem_write, bus.branch,
                  bus.jump, bus.reg_dst, bus.illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge CLK);
    #2;
  endtask

  logic [31:0] tbl_i [6];
  logic [6:0]  tbl_c [6];

  initial begin
    checks = 0;
    errors = 0;
    tbl_i[0] = 32'h8C22_0004; tbl_c[0] = 7'h60; // lw
    tbl_i[1] = 32'hAC22_0004; tbl_c[1] = 7'h10; // sw
    tbl_i[2] = 32'h1022_0003; tbl_c[2] = 7'h08; // beq
    tbl_i[3] = 32'h03E0_0008; tbl_c[3] = 7'h04; // jr
    tbl_i[4] = 32'h0000_0001; tbl_c[4] = 7'h01; // R-type funct 0x01
    tbl_i[5] = 32'h0800_0040; tbl_c[5] = 7'h04; // j

    RST_N          = 1'b0;
    bus.if_valid   = 1'b0;
    bus.if_instr   = '0;
    bus.if_pcplus4 = '0;
    bus.flush      = 1'b0;
    bus.ex_memtoreg = 1'b0;
    bus.ex_rt      = '0;
    bus.wb_we      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;

    edge_step();
    edge_step();
    #1;
    chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_stall",    {31'd0, bus.stall}, 32'd0);
    chk("rst_ctl",      {25'd0, w_ctl}, 32'd0);
    chk("rst_rs_data",  bus.rs_data, 32'd0);
    chk("rst_imm_sext", bus.imm_sext, 32'd0);
    chk("rst_pcplus4",  bus.id_pcplus4, 32'd0);
    RST_N = 1'b1;

    // Write r5 and load add $3,$5,$0 on the same edge.
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    bus.if_valid = 1'b1; bus.if_instr = 32'h00A0_1820; bus.if_pcplus4 = 32'h104;
    edge_step();
    bus.wb_we = 1'b0;
    #1;
    chk("wr_id_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("wr_rs_data",  bus.rs_data, 32'h1234);
    chk("wr_ctl",      {25'd0, w_ctl}, 32'h42);
    chk("wr_rd_addr",  {27'd0, bus.rd_addr}, 32'd3);
    chk("wr_pcplus4",  bus.id_pcplus4, 32'h104);

    // add $2,$7,$0 while r7 is being written this cycle.
    bus.if_instr = 32'h00E0_1020;
    edge_step();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hCAFE;
    #1;
`ifdef DECODE_BYPASS_EN
    chk("byp_same_cycle", bus.rs_data, 32'hCAFE);
`else
    chk("byp_same_cycle", bus.rs_data, 32'h0);
`endif
    edge_step();
    bus.wb_we = 1'b0;
    #1;
    chk("byp_next_cycle", bus.rs_data, 32'hCAFE);

    // Load-use on rs: add $6,$4,$5 behind a load to r4.
    bus.if_instr = 32'h0085_3020;
    edge_step();
    bus.ex_memtoreg = 1'b1; bus.ex_rt = 5'd4;
    bus.if_instr = 32'h34C7_0001;
    #1;
    chk("lu_stall",  {31'd0, bus.stall}, 32'd1);
    chk("lu_ctl",    {25'd0, w_ctl}, 32'd0);
    edge_step();
    #1;
    chk("lu_hold1_funct", {26'd0, bus.alu_funct}, 32'h20);
    edge_step();
    #1;
    chk("lu_hold2_rd",    {27'd0, bus.rd_addr}, 32'd6);
    chk("lu_hold2_stall", {31'd0, bus.stall}, 32'd1);
    bus.ex_rt = 5'd5;
    #1;
    chk("lu_rt_stall", {31'd0, bus.stall}, 32'd1);
    bus.ex_rt = 5'd0;
    #1;
    chk("lu_r0_stall", {31'd0, bus.stall}, 32'd0);
    bus.ex_memtoreg = 1'b0;
    #1;
    chk("lu_release_ctl", {25'd0, w_ctl}, 32'h42);

    // Flush and stall together, plus a write to r0.
    bus.ex_memtoreg = 1'b1; bus.ex_rt = 5'd4; bus.flush = 1'b1;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF;
    #1;
    chk("fl_pre_stall", {31'd0, bus.stall}, 32'd1);
    edge_step();
    bus.flush = 1'b0; bus.wb_we = 1'b0;
    #1;
    chk("fl_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("fl_stall",    {31'd0, bus.stall}, 32'd0);
    chk("fl_ctl",      {25'd0, w_ctl}, 32'd0);
    chk("fl_r0_read",  bus.rs_data, 32'd0);
    bus.ex_memtoreg = 1'b0; bus.ex_rt = 5'd0;

    // jal
    bus.if_instr = 32'h0C00_0010;
    edge_step();
    #1;
    chk("jal_rd_addr", {27'd0, bus.rd_addr}, 32'd31);
    chk("jal_ctl",     {25'd0, w_ctl}, 32'h46);

    // op 0x3F
    bus.if_instr = 32'hFC00_0000;
    edge_step();
    #1;
    chk("op3f_ctl", {25'd0, w_ctl}, 32'h01);

    // addi $1,$0,0x8000
    bus.if_instr = 32'h2001_8000;
    edge_step();
    #1;
    chk("addi_sext", bus.imm_sext, 32'hFFFF_8000);
    chk("addi_zext", bus.imm_zext, 32'h0000_8000);
    chk("addi_ctl",  {25'd0, w_ctl}, 32'h40);

    for (int k = 0; k < 6; k++) begin
      bus.if_instr = tbl_i[k];
      edge_step();
      #1;
      chk($sformatf("tbl%0d_ctl", k), {25'd0, w_ctl}, {25'd0, tbl_c[k]});
    end

    // Bubble from IF.
    bus.if_valid = 1'b0; bus.if_instr = 32'h00A0_1820;
    edge_step();
    #1;
    chk("bub_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("bub_ctl",      {25'd0, w_ctl}, 32'd0);

    // Reset in the middle of a stall.
    bus.if_valid = 1'b1; bus.if_instr = 32'h0085_3020; bus.if_pcplus4 = 32'h150;
    edge_step();
    bus.ex_memtoreg = 1'b1; bus.ex_rt = 5'd4;
    #1;
    chk("rs_pre_stall", {31'd0, bus.stall}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rs_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rs_stall",    {31'd0, bus.stall}, 32'd0);
    chk("rs_pcplus4",  bus.id_pcplus4, 32'd0);
    chk("rs_rs_addr",  {27'd0, bus.rs_addr}, 32'd0);
    bus.ex_memtoreg = 1'b0; bus.ex_rt = 5'd0;
    bus.if_instr = 32'h00A0_1820; bus.if_pcplus4 = 32'h200;
    RST_N = 1'b1;
    edge_step();
    #1;
    chk("post_rst_id_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("post_rst_r5",       bus.rs_data, 32'd0);
    chk("post_rst_pcplus4",  bus.id_pcplus4, 32'h200);
    chk("post_rst_ctl",      {25'd0, w_ctl}, 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
